// File: rtl/mult_nib_pkg.sv
// mult_nib_pkg
// Shared types and helpers for the nibble-iterative multiplier.
//   state_t : controller states IDLE / RUN / DONE
//   NIB     : nibble width fed to the 4x4 core
//   npass() : number of core passes for a W x W product
//   nib()   : extract nibble idx from a value up to 16 bits wide
package mult_nib_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIB = 4;

  function automatic int npass(input int w);
    return (w / NIB) * (w / NIB);
  endfunction

  function automatic logic [NIB-1:0] nib(input logic [15:0] v, input logic [1:0] idx);
    return v[idx*NIB +: NIB];
  endfunction

endpackage

// File: rtl/main.sv
// main
// Combinational 4x4 unsigned multiplier core.
//   x : multiplicand nibble
//   y : multiplier nibble
//   o : 8-bit product x*y
module main (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] o
);

  logic [7:0] pp0, pp1, pp2, pp3;
  logic [7:0] sum01, sum23;

  assign pp0 = y[0] ? {4'b0000, x}        : 8'h00;
  assign pp1 = y[1] ? {3'b000, x, 1'b0}   : 8'h00;
  assign pp2 = y[2] ? {2'b00, x, 2'b00}   : 8'h00;
  assign pp3 = y[3] ? {1'b0, x, 3'b000}   : 8'h00;

  // Two-level reduction tree; the 4x4 product never exceeds 8 bits.
  assign sum01 = pp0 + pp1;
  assign sum23 = pp2 + pp3;
  assign o     = sum01 + sum23;

endmodule

// File: rtl/nib_pair_sel.sv
// nib_pair_sel
// Finds the first nibble pair (i,j), in row-major order at or after linear
// index start, whose a-nibble and b-nibble are both flagged in the masks.
// With all-ones masks this is plain sequential stepping; with data-derived
// masks it implements zero skipping.
//   a_mask, b_mask : per-nibble eligibility flags
//   start          : first linear index (i*NNIB + j) to consider
//   sel_i, sel_j   : selected pair
//   found          : a pair exists at or after start
module nib_pair_sel #(
  parameter int NNIB  = 2,
  parameter int NPASS = 4
) (
  input  logic [NNIB-1:0] a_mask,
  input  logic [NNIB-1:0] b_mask,
  input  logic [4:0]      start,
  output logic [1:0]      sel_i,
  output logic [1:0]      sel_j,
  output logic            found
);

  // Scan from the top down so the lowest qualifying index wins.
  always_comb begin
    found = 1'b0;
    sel_i = 2'd0;
    sel_j = 2'd0;
    for (int k = NPASS - 1; k >= 0; k--) begin
      if ((5'(k) >= start) && a_mask[k / NNIB] && b_mask[k % NNIB]) begin
        found = 1'b1;
        sel_i = 2'(k / NNIB);
        sel_j = 2'(k % NNIB);
      end
    end
  end

endmodule

// File: rtl/mult_nib_iter_ctrl.sv
// mult_nib_iter_ctrl
// Computes an unsigned W x W product by time-sharing one 4x4 core, one
// nibble pair per cycle, accumulating shifted partial products.
// Optional feature macro: MULT_NIB_ZERO_SKIP_EN (skip pairs with a zero
// nibble; latency becomes the number of nonzero pairs).
//   clk, rst            : clock, async active-high reset
//   in_valid, in_ready  : operand handshake
//   a, b                : W-bit unsigned operands
//   out_valid, out_ready: result handshake
//   p                   : 2W-bit product
//   busy                : high in RUN or DONE
module mult_nib_iter_ctrl
  import mult_nib_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p,
  output logic           busy
);

  localparam int NNIB  = W / NIB;
  localparam int NPASS = npass(W);

  state_t         state;
  logic [W-1:0]   a_reg, b_reg;
  logic [1:0]     i, j;
  logic [2*W-1:0] acc, sum;
  logic [3:0]     core_x, core_y;
  logic [7:0]     core_o;

  logic [NNIB-1:0] first_am, first_bm, next_am, next_bm;
  logic [1:0]      first_i, first_j, next_i, next_j;
  logic            first_found, next_found;
  logic [4:0]      next_start;

`ifdef MULT_NIB_ZERO_SKIP_EN
  logic [NNIB-1:0] a_mask, b_mask, a_mask_in, b_mask_in;

  always_comb begin
    a_mask_in = '0;
    b_mask_in = '0;
    for (int k = 0; k < NNIB; k++) begin
      a_mask_in[k] = |a[k*NIB +: NIB];
      b_mask_in[k] = |b[k*NIB +: NIB];
    end
  end

  assign first_am = a_mask_in;
  assign first_bm = b_mask_in;
  assign next_am  = a_mask;
  assign next_bm  = b_mask;
`else
  assign first_am = '1;
  assign first_bm = '1;
  assign next_am  = '1;
  assign next_bm  = '1;
`endif

  assign core_x = nib(16'(a_reg), i);
  assign core_y = nib(16'(b_reg), j);

  main u_core (
    .x (core_x),
    .y (core_y),
    .o (core_o)
  );

  // Partial product placed at nibble weight i+j; 2W bits hold any sum exactly.
  assign sum = acc + ((2*W)'(core_o) << (NIB * (int'(i) + int'(j))));

  assign next_start = 5'(int'(i) * NNIB + int'(j) + 1);

  nib_pair_sel #(.NNIB(NNIB), .NPASS(NPASS)) u_sel_first (
    .a_mask (first_am),
    .b_mask (first_bm),
    .start  (5'd0),
    .sel_i  (first_i),
    .sel_j  (first_j),
    .found  (first_found)
  );

  nib_pair_sel #(.NNIB(NNIB), .NPASS(NPASS)) u_sel_next (
    .a_mask (next_am),
    .b_mask (next_bm),
    .start  (next_start),
    .sel_i  (next_i),
    .sel_j  (next_j),
    .found  (next_found)
  );

  // in_ready is held low during reset itself, and rises as soon as it releases.
  assign in_ready = (state == IDLE) && !rst;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      i         <= 2'd0;
      j         <= 2'd0;
      out_valid <= 1'b0;
      p         <= '0;
`ifdef MULT_NIB_ZERO_SKIP_EN
      a_mask    <= '0;
      b_mask    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
            acc   <= '0;
`ifdef MULT_NIB_ZERO_SKIP_EN
            a_mask <= a_mask_in;
            b_mask <= b_mask_in;
`endif
            if (first_found) begin
              i     <= first_i;
              j     <= first_j;
              state <= RUN;
            end else begin
              // No nonzero pair: the product is zero and is ready at once.
              i         <= 2'd0;
              j         <= 2'd0;
              p         <= '0;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        RUN: begin
          acc <= sum;
          if (next_found) begin
            i <= next_i;
            j <= next_j;
          end else begin
            p         <= sum;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
